// File: rtl/pipelined_power_shifter.sv
// Pipelined power-of-two scaler for the neuron datapath.
// Multiplies or divides a fixed-point value by 2^power.
module pipelined_power_shifter #(
   parameter int WIDTH  = 32,
   parameter int PWIDTH = 8,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  base,
   input  logic [PWIDTH-1:0] power,
   input  logic [1:0]        mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              ovf
);

   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [31:0] WU = WIDTH;

   typedef struct packed {
      logic [WIDTH-1:0]  base;
      logic [PWIDTH-1:0] power;
      logic [1:0]        mode;
   } acc_t;

   typedef struct packed {
      logic [WIDTH-1:0]  base;
      logic [1:0]        mode;
      logic              dir;
      logic [PWIDTH-1:0] mag;
      logic              big;
   } dec_t;

   typedef struct packed {
      logic [WIDTH-1:0] sh;
      logic [1:0]       mode;
      logic             neg;
      logic             ovf;
      logic             rnd;
   } shf_t;

   logic adv;

   logic a_v;
   logic d_v;
   logic s_v;

   acc_t a_q;
   dec_t d_q;
   dec_t d_n;
   shf_t s_q;
   shf_t s_n;

   logic [2*WIDTH-1:0] wide;
   logic [WIDTH-1:0]   ext;
   logic [WIDTH-1:0]   rsh;
   logic [AW-1:0]      ridx;
   logic               sgn;

   logic [WIDTH-1:0]   res_n;

   // One stall signal freezes every rank at once.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Operand capture: the input ports feed flops only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_v <= 1'b0;
         a_q <= '0;
      end else if (adv) begin
         a_v        <= in_valid;
         a_q.base   <= base;
         a_q.power  <= power;
         a_q.mode   <= mode;
      end
   end

   // Decode: direction, shift magnitude and out-of-range flag.
   always_comb begin
      d_n      = '0;
      d_n.base = a_q.base;
      d_n.mode = a_q.mode;
      d_n.dir  = a_q.power[PWIDTH-1];
      d_n.mag  = d_n.dir ? -a_q.power : a_q.power;
      d_n.big  = (32'(d_n.mag) >= WU);
   end

   // Decode rank register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_v <= 1'b0;
         d_q <= '0;
      end else if (adv) begin
         d_v <= a_v;
         d_q <= d_n;
      end
   end

   // Shift: both directions, overflow detect and rounding bit.
   always_comb begin
      s_n      = '0;
      sgn      = d_q.mode[0] & d_q.base[WIDTH-1];
      ext      = {WIDTH{sgn}};
      wide     = {ext, d_q.base} << d_q.mag;
      rsh      = d_q.base >> d_q.mag;
      if (d_q.mode[0]) begin
         rsh = $signed(d_q.base) >>> d_q.mag;
      end
      ridx     = AW'(d_q.mag) - AW'(1);
      s_n.mode = d_q.mode;
      s_n.neg  = d_q.base[WIDTH-1];
      if (d_q.dir) begin
         s_n.sh  = d_q.big ? ext : rsh;
         s_n.rnd = (ROUND != 0) && !d_q.big &&
                   (d_q.mag != '0) && d_q.base[ridx];
      end else begin
         s_n.sh = d_q.big ? '0 : wide[WIDTH-1:0];
         if (d_q.big) begin
            s_n.ovf = |d_q.base;
         end else if (d_q.mode[0]) begin
            s_n.ovf = wide[2*WIDTH-1:WIDTH-1] !=
                      {(WIDTH+1){sgn}};
         end else begin
            s_n.ovf = |wide[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Shift rank register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_v <= 1'b0;
         s_q <= '0;
      end else if (adv) begin
         s_v <= d_v;
         s_q <= s_n;
      end
   end

   // Round-up add, then clamp when overflow saturation is on.
   always_comb begin
      res_n = s_q.sh + WIDTH'(s_q.rnd);
      if (s_q.ovf && s_q.mode[1]) begin
         if (!s_q.mode[0]) begin
            res_n = '1;
         end else if (s_q.neg) begin
            res_n = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            res_n = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end
   end

   // Output rank register; holds while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= s_v;
         result    <= res_n;
         ovf       <= s_q.ovf;
      end
   end

endmodule

// File: tb/tb_pipelined_power_shifter.sv
// Bench for pipelined_power_shifter: truncating and rounding
// instances share stimulus and are scored against one model.
module tb_pipelined_power_shifter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] base;
   logic [7:0]  power;
   logic [1:0]  mode;
   logic        out_ready;

   logic        in_ready_a;
   logic        out_valid_a;
   logic [31:0] result_a;
   logic        ovf_a;

   logic        in_ready_b;
   logic        out_valid_b;
   logic [31:0] result_b;
   logic        ovf_b;

   int n_chk;
   int n_fail;

   logic [32:0] qa[$];
   logic [32:0] qb[$];

   logic [31:0] vb[21];
   logic [7:0]  vp[21];
   logic [1:0]  vm[21];

   pipelined_power_shifter #(
      .WIDTH(32), .PWIDTH(8), .ROUND(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .base(base), .power(power), .mode(mode),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .result(result_a), .ovf(ovf_a)
   );

   pipelined_power_shifter #(
      .WIDTH(32), .PWIDTH(8), .ROUND(1)
   ) u_rnd (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .base(base), .power(power), .mode(mode),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .result(result_b), .ovf(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [32:0] act,
                        input logic [32:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Plain arithmetic: value * 2^p, or floor(value / 2^-p).
   function automatic logic [32:0] model(input logic [31:0] b,
                                         input logic [7:0]  pw,
                                         input logic [1:0]  md,
                                         input bit          rd);
      int     p;
      int     m;
      longint v;
      longint full;
      longint r;
      longint d;
      bit     o;
      p = int'($signed(pw));
      v = md[0] ? longint'($signed(b)) : longint'(b);
      o = 1'b0;
      r = 0;
      if (p >= 0) begin
         if (p >= 32) begin
            o = (b != 0);
         end else begin
            full = v * (longint'(1) << p);
            r = full;
            if (md[0])
               o = (full < -(longint'(1) << 31)) ||
                   (full >= (longint'(1) << 31));
            else
               o = (p > 0) && (v >= (longint'(1) << (32 - p)));
         end
         if (o && md[1]) begin
            if (!md[0]) r = (longint'(1) << 32) - 1;
            else if (v < 0) r = -(longint'(1) << 31);
            else r = (longint'(1) << 31) - 1;
         end
      end else begin
         m = -p;
         if (m >= 32) begin
            r = (v < 0) ? -1 : 0;
         end else begin
            d = longint'(1) << m;
            if (rd) v = v + d / 2;
            r = v / d;
            if ((v % d != 0) && (v < 0)) r = r - 1;
         end
      end
      return {o, r[31:0]};
   endfunction

   // Scoreboard bookkeeping on handshakes; reset discards all.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (out_valid_a && out_ready && qa.size() != 0) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         if (in_valid && in_ready_a) begin
            qa.push_back(model(base, power, mode, 1'b0));
            qb.push_back(model(base, power, mode, 1'b1));
         end
      end
   end

   // Compare every presented result against the model.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("in_ready", {32'd0, in_ready_a},
               {32'd0, out_ready | ~out_valid_a});
         check("valid_pair", {32'd0, out_valid_b},
               {32'd0, out_valid_a});
         if (out_valid_a) begin
            if (qa.size() == 0) begin
               check("unexpected_out", {ovf_a, result_a}, 33'hx);
            end else begin
               check("trunc_out", {ovf_a, result_a}, qa[0]);
               check("round_out", {ovf_b, result_b}, qb[0]);
            end
         end
      end
   end

   task automatic send(input int i);
      int n;
      bit ok;
      base     = vb[i];
      power    = vp[i];
      mode     = vm[i];
      in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         @(posedge clk);
         ok = in_ready_a;
         n++;
      end
      if (!ok) check("accept_timeout", 33'd0, 33'd1);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (qa.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(nm, 33'(qa.size()), 33'd0);
   endtask

   task automatic latency_check(input string nm);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_e%0d", nm, k),
               {32'd0, out_valid_a}, {32'd0, (k == 3)});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r0;
      int seen;
      n_chk = 0;
      n_fail = 0;
      vb[0]  = 32'h00000001; vp[0]  = 8'h04; vm[0]  = 2'b00;
      vb[1]  = 32'h80000000; vp[1]  = 8'hFC; vm[1]  = 2'b01;
      vb[2]  = 32'h80000000; vp[2]  = 8'hFC; vm[2]  = 2'b00;
      vb[3]  = 32'h40000000; vp[3]  = 8'h02; vm[3]  = 2'b11;
      vb[4]  = 32'h40000000; vp[4]  = 8'h02; vm[4]  = 2'b10;
      vb[5]  = 32'h40000000; vp[5]  = 8'h02; vm[5]  = 2'b00;
      vb[6]  = 32'hFFFFFFFF; vp[6]  = 8'h80; vm[6]  = 2'b01;
      vb[7]  = 32'hFFFFFFFF; vp[7]  = 8'h80; vm[7]  = 2'b00;
      vb[8]  = 32'h00000000; vp[8]  = 8'h7F; vm[8]  = 2'b00;
      vb[9]  = 32'h00000003; vp[9]  = 8'hFF; vm[9]  = 2'b00;
      vb[10] = 32'hFFFFFFFF; vp[10] = 8'hFF; vm[10] = 2'b00;
      vb[11] = 32'hFFFFFFFF; vp[11] = 8'h04; vm[11] = 2'b01;
      vb[12] = 32'h00000001; vp[12] = 8'h1F; vm[12] = 2'b01;
      vb[13] = 32'h00000001; vp[13] = 8'h1F; vm[13] = 2'b00;
      vb[14] = 32'hC0000000; vp[14] = 8'h01; vm[14] = 2'b11;
      vb[15] = 32'hA0000000; vp[15] = 8'h01; vm[15] = 2'b11;
      vb[16] = 32'h12345678; vp[16] = 8'h00; vm[16] = 2'b11;
      vb[17] = 32'h00000005; vp[17] = 8'h20; vm[17] = 2'b11;
      vb[18] = 32'h87654321; vp[18] = 8'hE0; vm[18] = 2'b01;
      vb[19] = 32'h87654321; vp[19] = 8'hF8; vm[19] = 2'b01;
      vb[20] = 32'h0000000B; vp[20] = 8'hFE; vm[20] = 2'b01;

      for (int i = 0; i < 21; i++) begin
         check($sformatf("model_rt%0d", i),
               model(vb[i], vp[i], vm[i], 1'b0),
               model(vb[i], vp[i], vm[i], 1'b0));
         n_chk--;
      end

      check("pin_shl4", model(vb[0], vp[0], vm[0], 0), 33'h0_00000010);
      check("pin_sra4", model(vb[1], vp[1], vm[1], 0), 33'h0_F8000000);
      check("pin_srl4", model(vb[2], vp[2], vm[2], 0), 33'h0_08000000);
      check("pin_sats", model(vb[3], vp[3], vm[3], 0), 33'h1_7FFFFFFF);
      check("pin_satu", model(vb[4], vp[4], vm[4], 0), 33'h1_FFFFFFFF);
      check("pin_wrap", model(vb[5], vp[5], vm[5], 0), 33'h1_00000000);
      check("pin_m128s", model(vb[6], vp[6], vm[6], 0), 33'h0_FFFFFFFF);
      check("pin_m128u", model(vb[7], vp[7], vm[7], 0), 33'h0_00000000);
      check("pin_p127", model(vb[8], vp[8], vm[8], 0), 33'h0_00000000);
      check("pin_rnd", model(vb[9], vp[9], vm[9], 1), 33'h0_00000002);
      check("pin_rndu", model(vb[10], vp[10], vm[10], 1), 33'h0_80000000);
      check("pin_big", model(vb[17], vp[17], vm[17], 0), 33'h1_7FFFFFFF);

      rst       = 1'b1;
      in_valid  = 1'b0;
      base      = '0;
      power     = '0;
      mode      = '0;
      out_ready = 1'b1;
      #2;
      check("rst_valid", {32'd0, out_valid_a}, 33'd0);
      check("rst_out", {ovf_a, result_a}, 33'd0);
      check("rst_ready", {32'd0, in_ready_a}, 33'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      send(0);
      latency_check("lat");
      wait_drain("drain_lat");

      for (int i = 1; i < 21; i++) send(i);
      wait_drain("drain_table");

      fork
         begin
            for (int i = 11; i < 17; i++) send(i);
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            r0 = result_a;
            check("stall_valid", {32'd0, out_valid_a}, 33'd1);
            check("stall_ready0", {32'd0, in_ready_a}, 33'd0);
            @(negedge clk);
            check("stall_stable", {1'b0, result_a}, {1'b0, r0});
            check("stall_ready1", {32'd0, in_ready_a}, 33'd0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain("drain_bp");

      for (int i = 3; i < 7; i++) send(i);
      check("pre_rst_valid", {32'd0, out_valid_a}, 33'd1);
      rst = 1'b1;
      #1;
      check("async_valid", {31'd0, out_valid_b, out_valid_a}, 33'd0);
      check("async_out", {ovf_a, result_a}, 33'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid_a) seen++;
      end
      check("post_rst_quiet", 33'(seen), 33'd0);

      send(15);
      latency_check("lat_rst");
      wait_drain("drain_end");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_power_shifter.md
Name: pipelined_power_shifter

Overview:
- Parametrised successor to the single-cycle power shifter. Multiplies or divides a fixed-point value by 2^power, where power is a signed two's-complement exponent.
- Adds a 3-stage pipeline with valid/ready handshake, per-transfer signed/unsigned and saturate modes, overflow flag, and optional round-half-up on right shifts.
- Sits between neuron weight/activation datapaths and the accumulator as the scaling stage.

Parameters:
- WIDTH, 32, data width of base and result (>=4).
- PWIDTH, 8, width of signed power input; magnitude range 0..2^(PWIDTH-1).
- ROUND, 0, 1 = right shifts round half-up using the last discarded bit; 0 = truncate.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  transfer request for base/power/mode.
- in_ready  output  1  block accepts when in_valid and in_ready are both high at a clk edge.
- base  input  WIDTH  operand.
- power  input  PWIDTH  signed exponent; >=0 shifts left, <0 shifts right by -power.
- mode  input  2  [0] = signed (arithmetic right shift, signed overflow/saturation); [1] = saturate on left-shift overflow.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
- result  output  WIDTH  shifted value.
- ovf  output  1  left-shift overflow occurred for this result, whether or not it was saturated.

Behaviour:
- Reset (async, rst=1): all stage valid bits, out_valid, result, ovf and all internal registers go to 0 immediately. On deassertion the pipeline is empty and in_ready=1.
- Advance: adv = out_ready | ~out_valid. in_ready = adv. All three stages move together when adv=1 and hold everything when adv=0. A bubble (stage valid=0) propagates as a bubble.
- Latency: a transfer accepted at edge N gives out_valid=1 after edge N+3, provided adv stayed 1. Throughput is 1 per cycle.
- Stage 1 (decode): registers base and mode.
  - Computes dir = power[PWIDTH-1].
  - Computes mag = dir ? -power : power as a PWIDTH-bit unsigned value; -2^(PWIDTH-1) yields mag = 2^(PWIDTH-1).
  - Computes big = (mag >= WIDTH).
- Stage 2 (shift):
  - Left: sh = base << mag, truncated to WIDTH; 0 if big.
  - Left overflow, unsigned: any discarded bit is 1.
  - Left overflow, signed: any discarded bit or the new sign bit differs from base[WIDTH-1].
  - If big, ovf = (base != 0).
  - Right: zero-fill (unsigned) or sign-fill (signed). If big, result is all zeros, or all copies of the sign bit when signed.
  - Right rounding (ROUND=1, 1 <= mag <= WIDTH-1): rnd = base[mag-1], added in stage 3. No carry out of WIDTH is possible. No rounding when mag=0 or big.
- Stage 3 (saturate/output): result = sh + rnd.
  - If ovf and mode[1]=1: unsigned gives all ones. Signed gives 0111..1 when base was non-negative, 1000..0 when negative.
  - If ovf and mode[1]=0: the truncated value passes through with ovf=1.
  - ovf is always 0 for right shifts and for power=0.
- Output holds stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- Reset mid-stream discards all in-flight transfers; no partial result is emitted.
- Mode bits are sampled with base/power at acceptance. Changing mode while transfers are in flight does not affect them.

Test Plan:
- WIDTH=32, PWIDTH=8, ROUND=0. base=0x00000001, power=4, mode=00, out_ready=1 -> result=0x00000010, ovf=0, out_valid exactly 3 edges after acceptance.
- base=0x80000000, power=8'hFC (-4): mode=01 -> 0xF8000000; mode=00 -> 0x08000000; ovf=0 in both cases.
- base=0x40000000, power=2: mode=11 -> 0x7FFFFFFF, ovf=1; mode=10 -> 0xFFFFFFFF, ovf=1; mode=00 -> 0x00000000, ovf=1.
- Exponent extremes:
  - power=8'h80 (-128): base=0xFFFFFFFF gives 0xFFFFFFFF with mode=01 and 0x00000000 with mode=00.
  - power=8'h7F (127): base=0 gives 0 with ovf=0.
  - ROUND=1, base=0x00000003, power=-1 -> 0x00000002.
- Backpressure: 6 back-to-back transfers with out_ready low for 2 cycles mid-stream -> all 6 results delivered in order with none lost or duplicated. in_ready=0 exactly while out_valid=1 and out_ready=0. result is stable during the stall.
- Assert rst for 1 cycle with 3 transfers in flight -> out_valid=0 asynchronously and none of the 3 results appears. The first post-reset transfer emerges correctly after 3 cycles.
